pmu_bank_arbiter: RTL and testbench

// Shares the single PMU counter-bank access port (level enable/valid handshake, 8-bit word address,
// 64-bit data) between N_REQ requesters: AXI read path, AXI write path and the periodic sampler.

---
 rtl/pmu_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_pmu_bank_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_bank_arbiter.sv
// Round-robin arbiter sharing one PMU counter-bank port (read/write level handshake) among N_REQ requesters.
// Latency: grant 1 cycle after request in IDLE; response 1 cycle after synchronised bank valid (or timeout).
// Backpressure: one bank transaction in flight; other requesters hold req_valid until their req_ready pulse.
module pmu_bank_arbiter #(
   parameter int N_REQ   = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESETN,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_error,
   output logic                      bank_read_enable,
   output logic [ADDR_W-1:0]         bank_read_address,
   input  logic                      bank_read_valid,
   input  logic [DATA_W-1:0]         bank_read_data,
   output logic                      bank_write_enable,
   output logic [ADDR_W-1:0]         bank_write_address,
   output logic [DATA_W-1:0]         bank_write_data,
   input  logic                      bank_write_valid
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam bit TO_EN = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   cur_idx;
   logic               cur_write;
   logic [CNT_W-1:0]   cnt;

   logic               rd_s1, rd_s2;
   logic               wr_s1, wr_s2;
   logic               sync_vld;
   logic               timed_out;

   logic               pick_vld;
   logic [IDX_W-1:0]   pick_idx;
   logic [ADDR_W-1:0]  pick_addr;
   logic [DATA_W-1:0]  pick_wdata;
   logic [IDX_W-1:0]   rr_next;
   int                 cand;

   // Two-flop synchronisers for the bank acknowledge levels.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_s1 <= 1'b0;
         rd_s2 <= 1'b0;
         wr_s1 <= 1'b0;
         wr_s2 <= 1'b0;
      end else begin
         rd_s1 <= bank_read_valid;
         rd_s2 <= rd_s1;
         wr_s1 <= bank_write_valid;
         wr_s2 <= wr_s1;
      end
   end

   // Only the ack belonging to the transaction in flight matters.
   assign sync_vld  = cur_write ? wr_s2 : rd_s2;
   assign timed_out = TO_EN && (cnt == CNT_MAX);
   assign rr_next   = (cur_idx == IDX_W'(N_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);

   // Round-robin search: first pending requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(rr_ptr) + k) % N_REQ;
         if (!pick_vld && req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(cand);
         end
      end
   end

   assign pick_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
   assign pick_wdata = req_wdata[pick_idx*DATA_W +: DATA_W];

   // Transaction FSM with all handshake and response outputs registered.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state              <= IDLE;
         rr_ptr             <= '0;
         cur_idx            <= '0;
         cur_write          <= 1'b0;
         cnt                <= '0;
         req_ready          <= '0;
         rsp_valid          <= '0;
         rsp_rdata          <= '0;
         rsp_error          <= 1'b0;
         bank_read_enable   <= 1'b0;
         bank_read_address  <= '0;
         bank_write_enable  <= 1'b0;
         bank_write_address <= '0;
         bank_write_data    <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  req_ready[pick_idx] <= 1'b1;
                  cur_idx             <= pick_idx;
                  cur_write           <= req_write[pick_idx];
                  cnt                 <= '0;
                  if (req_write[pick_idx]) begin
                     bank_write_enable  <= 1'b1;
                     bank_write_address <= pick_addr;
                     bank_write_data    <= pick_wdata;
                  end else begin
                     bank_read_enable  <= 1'b1;
                     bank_read_address <= pick_addr;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (sync_vld || timed_out) begin
                  // A real ack wins over a simultaneous expiry.
                  bank_read_enable   <= 1'b0;
                  bank_write_enable  <= 1'b0;
                  rsp_valid[cur_idx] <= 1'b1;
                  rsp_error          <= !sync_vld;
                  rsp_rdata          <= (sync_vld && !cur_write) ? bank_read_data : '0;
                  cnt                <= '0;
                  state              <= RELEASE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               // Wait for the bank to drop its ack; a stuck ack is abandoned on expiry.
               if (!sync_vld || timed_out) begin
                  rr_ptr <= rr_next;
                  state  <= IDLE;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmu_bank_arbiter.sv
// Randomised self-checking bench for pmu_bank_arbiter with a behavioural bank and reference memory.
module tb_pmu_bank_arbiter;
   localparam int N  = 3;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_write = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_error;
   logic              bank_read_enable;
   logic [AW-1:0]     bank_read_address;
   logic              bank_read_valid;
   logic [DW-1:0]     bank_read_data;
   logic              bank_write_enable;
   logic [AW-1:0]     bank_write_address;
   logic [DW-1:0]     bank_write_data;
   logic              bank_write_valid;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] bank_mem [256];
   logic [DW-1:0] ref_mem  [256];
   int            bank_mode = 0;   // 0 = acks after bank_delay, 1 = never acks
   int            bank_delay = 1;
   int            hold_extra = 0;
   logic [AW-1:0] last_wr_addr = '0;
   logic [DW-1:0] last_wr_data = '0;
   int            both_en = 0;

   always #5 clk = ~clk;

   pmu_bank_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .bank_read_enable(bank_read_enable), .bank_read_address(bank_read_address),
      .bank_read_valid(bank_read_valid), .bank_read_data(bank_read_data),
      .bank_write_enable(bank_write_enable), .bank_write_address(bank_write_address),
      .bank_write_data(bank_write_data), .bank_write_valid(bank_write_valid)
   );

   // Behavioural counter bank: 4-phase level handshake, driven away from the DUT clock edge.
   initial begin
      int  dly;
      int  hold;
      bit  ack;
      dly = 0; hold = 0; ack = 0;
      bank_read_valid = 1'b0; bank_write_valid = 1'b0; bank_read_data = '0;
      forever begin
         @(negedge clk);
         if (!ack) begin
            if ((bank_read_enable || bank_write_enable) && bank_mode == 0) begin
               if (dly >= bank_delay) begin
                  if (bank_read_enable) begin
                     bank_read_data  = bank_mem[bank_read_address];
                     bank_read_valid = 1'b1;
                  end else begin
                     bank_mem[bank_write_address] = bank_write_data;
                     last_wr_addr     = bank_write_address;
                     last_wr_data     = bank_write_data;
                     bank_write_valid = 1'b1;
                  end
                  ack = 1; dly = 0;
               end else begin
                  dly++;
               end
            end else if (!bank_read_enable && !bank_write_enable) begin
               dly = 0;
            end
         end else if (!bank_read_enable && !bank_write_enable) begin
            if (hold >= hold_extra) begin
               bank_read_valid = 1'b0; bank_write_valid = 1'b0;
               ack = 0; hold = 0;
            end else begin
               hold++;
            end
         end
      end
   end

   always @(negedge clk) if (bank_read_enable && bank_write_enable) both_en++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write[i]           = w;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
      req_valid[i]           = 1'b1;
   endtask

   task automatic wait_ready(output logic [N-1:0] rv);
      rv = '0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            rv = req_ready;
            break;
         end
      end
   endtask

   task automatic wait_rsp(output logic [N-1:0] vv, output logic [DW-1:0] d, output logic e, output int ncyc);
      vv = '0; d = '0; e = 1'b0; ncyc = 0;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            vv = rsp_valid; d = rsp_rdata; e = rsp_error; ncyc = n;
            break;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bank_read_enable || bank_write_enable || bank_read_valid || bank_write_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if ({bank_read_enable, bank_write_enable, req_ready, rsp_valid} !== '0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0", {bank_read_enable, bank_write_enable, req_ready, rsp_valid});
      end
      total++;
      if ({rsp_rdata, rsp_error} !== '0) begin
         bad++; $display("FAIL reset_rsp: got %h want 0", {rsp_rdata, rsp_error});
      end
      total++;
      if ({bank_read_address, bank_write_address, bank_write_data} !== '0) begin
         bad++; $display("FAIL reset_bank: got %h want 0", {bank_read_address, bank_write_address, bank_write_data});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      logic [N-1:0] rv, vv; logic [DW-1:0] d; logic e; int nc;
      bank_mode = 0; bank_delay = 2; hold_extra = 0;
      set_req(0, 1'b0, 8'h05, '0);
      wait_ready(rv);
      req_valid[0] = 1'b0;
      total++;
      if (rv !== 3'b001) begin bad++; $display("FAIL read_ready: got %b want 001", rv); end
      total++;
      if ({bank_read_enable, bank_read_address} !== {1'b1, 8'h05}) begin
         bad++; $display("FAIL read_issue: got en=%b addr=%h want en=1 addr=05", bank_read_enable, bank_read_address);
      end
      wait_rsp(vv, d, e, nc);
      total++;
      if ({vv, d, e} !== {3'b001, 64'hDEAD_BEEF_0000_0001, 1'b0}) begin
         bad++; $display("FAIL read_rsp: got v=%b d=%h e=%b want v=001 d=deadbeef00000001 e=0", vv, d, e);
      end
      wait_idle();
   endtask

   task automatic test_single_write();
      logic [N-1:0] rv, vv; logic [DW-1:0] d; logic e; int nc;
      bank_mode = 0; bank_delay = 3; hold_extra = 1;
      set_req(1, 1'b1, 8'h10, 64'h1234);
      wait_ready(rv);
      req_valid[1] = 1'b0;
      total++;
      if (rv !== 3'b010) begin bad++; $display("FAIL write_ready: got %b want 010", rv); end
      total++;
      if ({bank_write_enable, bank_read_enable, bank_write_address, bank_write_data} !== {2'b10, 8'h10, 64'h1234}) begin
         bad++; $display("FAIL write_issue: got wen=%b ren=%b a=%h d=%h want wen=1 ren=0 a=10 d=1234",
                         bank_write_enable, bank_read_enable, bank_write_address, bank_write_data);
      end
      wait_rsp(vv, d, e, nc);
      total++;
      if ({vv, d, e} !== {3'b010, 64'h0, 1'b0}) begin
         bad++; $display("FAIL write_rsp: got v=%b d=%h e=%b want v=010 d=0 e=0", vv, d, e);
      end
      total++;
      if ({last_wr_addr, last_wr_data} !== {8'h10, 64'h1234}) begin
         bad++; $display("FAIL write_bank: got a=%h d=%h want a=10 d=1234", last_wr_addr, last_wr_data);
      end
      ref_mem[8'h10] = 64'h1234;
      wait_idle();
   endtask

   task automatic test_contention();
      logic [N-1:0] rv, vv, ev; logic [DW-1:0] d; logic e; int nc;
      logic [AW-1:0] cur_addr [N];
      int served [N];
      int expi;
      do_reset();
      bank_mode = 0;
      for (int k = 0; k < N; k++) begin
         cur_addr[k] = AW'(8'h20 + k);
         served[k] = 0;
         set_req(k, 1'b0, cur_addr[k], '0);
      end
      expi = 0;
      for (int g = 0; g < 6; g++) begin
         bank_delay = $urandom_range(0, 3); hold_extra = $urandom_range(0, 2);
         wait_ready(rv);
         ev = '0; ev[expi] = 1'b1;
         total++;
         if (rv !== ev) begin bad++; $display("FAIL contend_grant%0d: got %b want %b", g, rv, ev); end
         req_valid[expi] = 1'b0;
         wait_rsp(vv, d, e, nc);
         total++;
         if ({vv, d, e} !== {ev, ref_mem[cur_addr[expi]], 1'b0}) begin
            bad++; $display("FAIL contend_rsp%0d: got v=%b d=%h e=%b want v=%b d=%h e=0", g, vv, d, e, ev, ref_mem[cur_addr[expi]]);
         end
         if (vv == ev) served[expi]++;
         if (g < 5) begin
            cur_addr[expi] = AW'($urandom_range(0, 255));
            set_req(expi, 1'b0, cur_addr[expi], '0);
         end else begin
            req_valid = '0;
         end
         expi = (expi + 1) % N;
      end
      total++;
      if (served[0] != 2 || served[1] != 2 || served[2] != 2) begin
         bad++; $display("FAIL contend_fair: got %0d/%0d/%0d want 2/2/2", served[0], served[1], served[2]);
      end
      wait_idle();
   endtask

   task automatic test_timeout();
      logic [N-1:0] rv, vv; logic [DW-1:0] d; logic e; int nc;
      bank_mode = 1;
      set_req(2, 1'b0, 8'h33, '0);
      wait_ready(rv);
      req_valid[2] = 1'b0;
      total++;
      if (rv !== 3'b100) begin bad++; $display("FAIL to_ready: got %b want 100", rv); end
      wait_rsp(vv, d, e, nc);
      total++;
      if ({vv, d, e, bank_read_enable} !== {3'b100, 64'h0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL to_rsp: got v=%b d=%h e=%b en=%b want v=100 d=0 e=1 en=0", vv, d, e, bank_read_enable);
      end
      total++;
      if (nc < TO || nc > TO + 2) begin bad++; $display("FAIL to_latency: got %0d want %0d..%0d", nc, TO, TO + 2); end
      bank_mode = 0; bank_delay = 1; hold_extra = 0;
      repeat (4) @(negedge clk);
      set_req(2, 1'b1, 8'h44, 64'hCAFE_F00D);
      wait_ready(rv);
      req_valid[2] = 1'b0;
      wait_rsp(vv, d, e, nc);
      total++;
      if ({rv, vv, e} !== {3'b100, 3'b100, 1'b0}) begin
         bad++; $display("FAIL to_recover: got rdy=%b v=%b e=%b want rdy=100 v=100 e=0", rv, vv, e);
      end
      ref_mem[8'h44] = 64'hCAFE_F00D;
      wait_idle();
   endtask

   task automatic test_reset_during_issue();
      logic [N-1:0] rv, vv; logic [DW-1:0] d; logic e; int nc; int spurious;
      bank_mode = 1;
      set_req(1, 1'b0, 8'h07, '0);
      wait_ready(rv);
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (bank_read_enable !== 1'b1) begin bad++; $display("FAIL rsti_pre: got en=%b want 1", bank_read_enable); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bank_read_enable, rsp_valid} !== 4'b0000) begin
         bad++; $display("FAIL rsti_async: got en=%b v=%b want en=0 v=000", bank_read_enable, rsp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bank_mode = 0; bank_delay = 1; hold_extra = 0;
      spurious = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid != '0 || bank_read_enable || bank_write_enable) spurious++;
      end
      total++;
      if (spurious != 0) begin bad++; $display("FAIL rsti_quiet: got %0d active cycles want 0", spurious); end
      set_req(0, 1'b0, 8'h05, '0);
      set_req(2, 1'b0, 8'h10, '0);
      wait_ready(rv);
      req_valid[0] = 1'b0;
      total++;
      if (rv !== 3'b001) begin bad++; $display("FAIL rsti_next: got %b want 001", rv); end
      wait_rsp(vv, d, e, nc);
      wait_ready(rv);
      req_valid[2] = 1'b0;
      wait_rsp(vv, d, e, nc);
      total++;
      if ({vv, d} !== {3'b100, ref_mem[8'h10]}) begin
         bad++; $display("FAIL rsti_second: got v=%b d=%h want v=100 d=%h", vv, d, ref_mem[8'h10]);
      end
      wait_idle();
   endtask

   task automatic test_stuck_valid();
      logic [N-1:0] rv, vv; logic [DW-1:0] d; logic e; int nc; int early; int n;
      logic [DW-1:0] wd;
      bank_mode = 0; bank_delay = 1; hold_extra = 12;
      wd = {$urandom, $urandom};
      set_req(0, 1'b1, 8'h50, wd);
      wait_ready(rv);
      req_valid[0] = 1'b0;
      wait_rsp(vv, d, e, nc);
      ref_mem[8'h50] = wd;
      set_req(1, 1'b0, 8'h50, '0);
      early = 0; n = 0;
      while (bank_write_valid && n < 60) begin
         @(negedge clk);
         n++;
         if (bank_read_enable || bank_write_enable || req_ready != '0) early++;
      end
      total++;
      if (early != 0 || n < 8) begin
         bad++; $display("FAIL stuck_hold: got early=%0d held=%0d want early=0 held>=8", early, n);
      end
      hold_extra = 0;
      wait_ready(rv);
      req_valid[1] = 1'b0;
      wait_rsp(vv, d, e, nc);
      total++;
      if ({rv, vv, d, e} !== {3'b010, 3'b010, wd, 1'b0}) begin
         bad++; $display("FAIL stuck_next: got rdy=%b v=%b d=%h e=%b want rdy=010 v=010 d=%h e=0", rv, vv, d, e, wd);
      end
      wait_idle();
   endtask

   task automatic test_random();
      logic [N-1:0] rv, vv, ev, mask, served; logic [DW-1:0] d, exp_d; logic e; int nc;
      logic [AW-1:0] ad [N];
      logic [DW-1:0] wdat [N];
      bit            wr [N];
      int            ptr, expi;
      do_reset();
      ptr = 0;
      bank_mode = 0;
      for (int r = 0; r < 14; r++) begin
         mask = N'($urandom_range(1, 7));
         bank_delay = $urandom_range(0, 5); hold_extra = $urandom_range(0, 3);
         for (int k = 0; k < N; k++) begin
            wr[k]   = 1'($urandom_range(0, 1));
            ad[k]   = AW'($urandom_range(0, 7));
            wdat[k] = {$urandom, $urandom};
            if (mask[k]) set_req(k, wr[k], ad[k], wdat[k]);
         end
         served = '0;
         for (int it = 0; it < N; it++) begin
            if (served != mask) begin
               expi = -1;
               for (int s = 0; s < N; s++)
                  if (expi < 0 && mask[(ptr + s) % N] && !served[(ptr + s) % N]) expi = (ptr + s) % N;
               ev = '0; ev[expi] = 1'b1;
               wait_ready(rv);
               total++;
               if (rv !== ev) begin bad++; $display("FAIL rand_grant r%0d: got %b want %b", r, rv, ev); end
               req_valid[expi] = 1'b0;
               exp_d = wr[expi] ? '0 : ref_mem[ad[expi]];
               if (wr[expi]) ref_mem[ad[expi]] = wdat[expi];
               wait_rsp(vv, d, e, nc);
               total++;
               if ({vv, d, e} !== {ev, exp_d, 1'b0}) begin
                  bad++; $display("FAIL rand_rsp r%0d: got v=%b d=%h e=%b want v=%b d=%h e=0", r, vv, d, e, ev, exp_d);
               end
               served[expi] = 1'b1;
               ptr = (expi + 1) % N;
            end
         end
         req_valid = '0;
         wait_idle();
      end
      total++;
      if (both_en != 0) begin bad++; $display("FAIL both_enables: got %0d cycles want 0", both_en); end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin
         bank_mem[a] = {$urandom, $urandom};
         ref_mem[a]  = bank_mem[a];
      end
      bank_mem[5] = 64'hDEAD_BEEF_0000_0001;
      ref_mem[5]  = 64'hDEAD_BEEF_0000_0001;
      test_reset();
      test_single_read();
      test_single_write();
      test_contention();
      test_timeout();
      test_reset_during_issue();
      test_stuck_valid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
